note_envelope: RTL and testbench



---
 rtl/note_envelope.sv | 145 ++++++++++++++
 tb/tb_note_envelope.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_envelope.sv
// ADSR amplitude shaper: gates a raw generator sample with an attack/decay/sustain/release gain.
// Note start waits for the generator's index-zero point so the waveform begins without a click.
module note_envelope #(
  parameter int unsigned TICK_DIV      = 32,
  parameter int unsigned ATTACK_STEP   = 4,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_LEVEL = 160,
  parameter int unsigned RELEASE_STEP  = 2
) (
  input  logic       CLK_32KHz,
  input  logic       reset,
  input  logic       gate,
  input  logic [7:0] inputSample,
  input  logic       indexZero,
  output logic [7:0] outputSample,
  output logic [7:0] envelopeGain,
  output logic       busy,
  output logic       noteDone
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0] SUS_GAIN = 8'(SUSTAIN_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       gain_q, gain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_d;
  logic             note_done_d;

  logic             rise;
  logic             counting;
  logic             tick;
  logic [8:0]       atk_sum, dec_diff, rel_diff;
  logic [7:0]       atk_gain, dec_gain, rel_gain;
  logic [15:0]      product;

  assign rise     = gate & ~gate_d;
  assign counting = (state_q == S_ATTACK) || (state_q == S_DECAY) || (state_q == S_RELEASE);
  assign tick     = counting && (cnt_q == TICK_LAST);

  // Saturating gain steps computed in 9 bits; bit 8 flags overflow/underflow.
  assign atk_sum  = {1'b0, gain_q} + 9'(ATTACK_STEP);
  assign dec_diff = {1'b0, gain_q} - 9'(DECAY_STEP);
  assign rel_diff = {1'b0, gain_q} - 9'(RELEASE_STEP);
  assign atk_gain = atk_sum[8] ? 8'hFF : atk_sum[7:0];
  assign dec_gain = (dec_diff[8] || (dec_diff[7:0] < SUS_GAIN)) ? SUS_GAIN : dec_diff[7:0];
  assign rel_gain = rel_diff[8] ? 8'h00 : rel_diff[7:0];

  assign product  = 16'(inputSample) * 16'(gain_q);

  assign busy         = (state_q != S_IDLE);
  assign envelopeGain = gain_q;

  always_ff @(posedge CLK_32KHz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gain_q       <= 8'h00;
      cnt_q        <= '0;
      gate_d       <= 1'b0;
      outputSample <= 8'h00;
      noteDone     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      cnt_q        <= cnt_d;
      gate_d       <= gate;
      outputSample <= product[15:8];
      noteDone     <= note_done_d;
    end
  end

  // Next state, gain and tick counter; gate events win over a same-cycle tick.
  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    cnt_d       = '0;
    note_done_d = 1'b0;

    if (counting) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_ARM;
      end
      S_ARM: begin
        if (!gate)          state_d = S_IDLE;
        else if (indexZero) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (tick) begin
          gain_d = atk_gain;
          if (atk_gain == 8'hFF) state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        if (!gate) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (tick) begin
          gain_d = dec_gain;
          if (dec_gain == SUS_GAIN) begin
            state_d = S_SUSTAIN;
            cnt_d   = '0;
          end
        end
      end
      S_SUSTAIN: begin
        if (!gate) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (rise) begin
          state_d = S_ATTACK;
          cnt_d   = '0;
        end else if (tick) begin
          gain_d = rel_gain;
          if (rel_gain == 8'h00) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            note_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gain_d  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_note_envelope.sv
// Directed bench for note_envelope: vector tables for reset and scaling, hand sequences for
// phase-aligned start, full ADSR timing, abort/retrigger, same-cycle gate/tick and mid-note reset.
module tb_note_envelope;

  logic       CLK_32KHz;
  logic       reset;
  logic       gate;
  logic [7:0] inputSample;
  logic       indexZero;
  logic [7:0] outputSample;
  logic [7:0] envelopeGain;
  logic       busy;
  logic       noteDone;

  int n_cmp;
  int n_err;
  int done_pulses;

  typedef struct {
    logic       rst;
    logic       g;
    logic       iz;
    logic [7:0] smp;
    logic [7:0] exp_gain;
    logic [7:0] exp_out;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t rst_tbl [5];
  vec_t scl_tbl [5];

  note_envelope dut (
    .CLK_32KHz   (CLK_32KHz),
    .reset       (reset),
    .gate        (gate),
    .inputSample (inputSample),
    .indexZero   (indexZero),
    .outputSample(outputSample),
    .envelopeGain(envelopeGain),
    .busy        (busy),
    .noteDone    (noteDone)
  );

  initial CLK_32KHz = 1'b0;
  always #5 CLK_32KHz = ~CLK_32KHz;

  always @(negedge CLK_32KHz) begin
    if (noteDone === 1'b1) done_pulses++;
  end

  task automatic clk_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_32KHz);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    reset       = v.rst;
    gate        = v.g;
    indexZero   = v.iz;
    inputSample = v.smp;
    clk_n(1);
    check({name, ".gain"}, int'(envelopeGain), int'(v.exp_gain));
    check({name, ".out"},  int'(outputSample), int'(v.exp_out));
    check({name, ".busy"}, int'(busy),         int'(v.exp_busy));
    check({name, ".done"}, int'(noteDone),     int'(v.exp_done));
  endtask

  initial begin
    int bad;
    n_cmp       = 0;
    n_err       = 0;
    done_pulses = 0;
    reset       = 1'b1;
    gate        = 1'b0;
    indexZero   = 1'b0;
    inputSample = 8'd200;

    //            rst   g     iz    smp  gain out busy  done
    rst_tbl[0] = '{1'b1, 1'b0, 1'b0, 200, 0,   0,  1'b0, 1'b0};
    rst_tbl[1] = '{1'b1, 1'b0, 1'b0, 200, 0,   0,  1'b0, 1'b0};
    rst_tbl[2] = '{1'b0, 1'b0, 1'b0, 200, 0,   0,  1'b0, 1'b0};
    rst_tbl[3] = '{1'b0, 1'b0, 1'b1, 200, 0,   0,  1'b0, 1'b0};
    rst_tbl[4] = '{1'b0, 1'b0, 1'b0, 255, 0,   0,  1'b0, 1'b0};

    // SUSTAIN at gain 160: out = smp*160 >> 8
    scl_tbl[0] = '{1'b0, 1'b1, 1'b0, 255, 160, 159, 1'b1, 1'b0};
    scl_tbl[1] = '{1'b0, 1'b1, 1'b0, 0,   160, 0,   1'b1, 1'b0};
    scl_tbl[2] = '{1'b0, 1'b1, 1'b0, 128, 160, 80,  1'b1, 1'b0};
    scl_tbl[3] = '{1'b0, 1'b1, 1'b1, 200, 160, 125, 1'b1, 1'b0};
    scl_tbl[4] = '{1'b0, 1'b1, 1'b0, 1,   160, 0,   1'b1, 1'b0};

    for (int i = 0; i < 5; i++) run_vec($sformatf("reset[%0d]", i), rst_tbl[i]);

    // Phase-aligned start: ARM until indexZero
    gate = 1'b1;
    clk_n(1);
    check("arm.busy", int'(busy), 1);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      clk_n(1);
      if (busy !== 1'b1 || envelopeGain !== 8'd0) bad++;
    end
    check("arm.wait", bad, 0);
    indexZero = 1'b1;
    clk_n(1);
    indexZero = 1'b0;
    check("attack.entry_gain", int'(envelopeGain), 0);
    clk_n(31);
    check("attack.pre_tick", int'(envelopeGain), 0);
    clk_n(1);
    check("attack.first_tick", int'(envelopeGain), 4);
    clk_n(2047 - 32);
    check("attack.tick63", int'(envelopeGain), 252);
    clk_n(1);
    check("attack.tick64", int'(envelopeGain), 255);

    // Decay to sustain, then hold
    clk_n(3039);
    check("decay.tick94", int'(envelopeGain), 161);
    clk_n(1);
    check("decay.tick95", int'(envelopeGain), 160);
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      clk_n(1);
      if (envelopeGain !== 8'd160 || busy !== 1'b1) bad++;
    end
    check("sustain.hold", bad, 0);

    for (int i = 0; i < 5; i++) run_vec($sformatf("scale[%0d]", i), scl_tbl[i]);

    // Release to zero
    gate = 1'b0;
    clk_n(1);
    check("release.entry_gain", int'(envelopeGain), 160);
    clk_n(2559);
    check("release.tick79", int'(envelopeGain), 2);
    check("release.tick79_done", int'(noteDone), 0);
    clk_n(1);
    check("release.end_gain", int'(envelopeGain), 0);
    check("release.end_done", int'(noteDone), 1);
    check("release.end_busy", int'(busy), 0);
    clk_n(1);
    check("release.done_clears", int'(noteDone), 0);

    // Gate pulse without indexZero aborts ARM
    gate = 1'b1;
    clk_n(3);
    check("abort.armed", int'(busy), 1);
    gate = 1'b0;
    clk_n(1);
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(noteDone), 0);
    check("abort.gain", int'(envelopeGain), 0);

    // Retrigger from RELEASE at gain 100
    gate = 1'b1;
    clk_n(1);
    indexZero = 1'b1;
    clk_n(1);
    indexZero = 1'b0;
    clk_n(800);
    check("retrig.attack100", int'(envelopeGain), 100);
    gate = 1'b0;
    clk_n(6);
    check("retrig.release_gain", int'(envelopeGain), 100);
    gate = 1'b1;
    clk_n(1);
    check("retrig.entry_gain", int'(envelopeGain), 100);
    check("retrig.busy", int'(busy), 1);
    clk_n(31);
    check("retrig.pre_tick", int'(envelopeGain), 100);
    clk_n(1);
    check("retrig.tick", int'(envelopeGain), 104);

    // Climb to 255 and check full-scale product latency
    inputSample = 8'd255;
    clk_n(1216);
    check("retrig.peak", int'(envelopeGain), 255);
    clk_n(1);
    check("scale.full", int'(outputSample), 254);
    clk_n(31);
    check("decay2.tick1", int'(envelopeGain), 254);

    // Mid-note reset with gate held high
    reset = 1'b1;
    clk_n(1);
    check("midreset.gain", int'(envelopeGain), 0);
    check("midreset.out", int'(outputSample), 0);
    check("midreset.busy", int'(busy), 0);
    check("midreset.done", int'(noteDone), 0);
    reset = 1'b0;
    clk_n(1);
    check("post_reset.rise", int'(busy), 1);
    gate = 1'b0;
    clk_n(1);
    check("post_reset.idle", int'(busy), 0);

    // Gate falls on the same cycle as an ATTACK tick at gain 40
    gate = 1'b1;
    clk_n(1);
    indexZero = 1'b1;
    clk_n(1);
    indexZero = 1'b0;
    clk_n(351);
    check("sametick.gain40", int'(envelopeGain), 40);
    gate = 1'b0;
    clk_n(1);
    check("sametick.release_gain", int'(envelopeGain), 40);
    check("sametick.busy", int'(busy), 1);
    clk_n(32);
    check("sametick.release_tick", int'(envelopeGain), 38);

    check("done.pulse_count", done_pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
